// File: rtl/intc_pkg.sv
// Shared types and helpers for the nested interrupt controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package intc_pkg;

  localparam int DEF_NUM_IRQ    = 4;
  localparam int DEF_NEST_DEPTH = 4;
  localparam int ID_W           = $clog2(DEF_NUM_IRQ);
  localparam int LVL_W          = $clog2(DEF_NEST_DEPTH + 1);

  // EPC stack entry for the default configuration.
  typedef struct packed {
    logic [31:0]     pc;
    logic [ID_W-1:0] id;
  } intc_stack_entry_t;

  // IDLE: stack empty, ACTIVE: partially filled, FULL: no room for another level.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_FULL
  } intc_state_e;

  // Id width that stays legal for a single-line controller.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Index of the lowest set bit; 0 when nothing is set (callers qualify with |v).
  function automatic int unsigned ffs_lowest(input logic [31:0] v);
    int unsigned r;
    r = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Find-first-set priority encoder: lowest set request index wins (NUM_IRQ <= 32).
// Latency: combinational.
// Backpressure: none.
module intc_prio_enc
  import intc_pkg::*;
#(
  parameter int NUM_IRQ = 4,
  localparam int IW     = id_width(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic [IW-1:0]      id,
  output logic               vld
);

  logic [31:0] req_ext;

  // Widen to the helper's fixed width and pick the lowest index.
  always_comb begin
    req_ext                = '0;
    req_ext[NUM_IRQ-1:0]   = req;
    id                     = IW'(ffs_lowest(req_ext));
    vld                    = |req;
  end

endmodule

// File: rtl/intc_nested.sv
// Prioritised, nestable interrupt controller with an EPC stack (nesting enabled by INTC_NEST_EN).
// Latency: irq rising edge to int_request pulse is 2 cycles.
// Backpressure: none; a full stack or cleared ie simply holds the request in pending.
module intc_nested
  import intc_pkg::*;
#(
  parameter int                NUM_IRQ    = 4,
  parameter int                NEST_DEPTH = 4,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] VEC_BASE   = 32'h0000_0400,
  parameter logic [ADDR_W-1:0] VEC_STRIDE = 32'h0000_0100,
  localparam int               IW         = id_width(NUM_IRQ),
  localparam int               LW         = $clog2(NEST_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_din,
  input  logic               ie_set,
  input  logic               ie_clr,
  input  logic               eret,
  input  logic [ADDR_W-1:0]  resume_pc,
  output logic               int_request,
  output logic [ADDR_W-1:0]  int_vector,
  output logic [IW-1:0]      int_id,
  output logic [ADDR_W-1:0]  epc_out,
  output logic               ie,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] in_service,
  output logic [LW-1:0]      nest_level,
  output logic               stack_full
);

`ifdef INTC_NEST_EN
  localparam int EFF_DEPTH = NEST_DEPTH;
`else
  localparam int EFF_DEPTH = 1;
`endif

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [IW-1:0]     id;
  } entry_t;

  entry_t             stack_q [EFF_DEPTH];
  intc_state_e        state_q, state_d;
  logic [NUM_IRQ-1:0] irq_q, pending_q, mask_q, in_service_q;
  logic [NUM_IRQ-1:0] edge_v, elig, acc_onehot, pop_onehot;
  logic [LW-1:0]      nest_q;
  logic               ie_q, ie_d, req_q;
  logic [IW-1:0]      id_q, cand_id, top_id;
  logic [ADDR_W-1:0]  vec_q, top_pc;
  logic               cand_vld, accept, pop, prio_ok;

  assign edge_v = irq & ~irq_q;
  assign elig   = pending_q & mask_q & ~in_service_q;

  intc_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio_enc (
    .req (elig),
    .id  (cand_id),
    .vld (cand_vld)
  );

  // Top-of-stack view; reads as zero when the stack is empty.
  always_comb begin
    top_pc = '0;
    top_id = '0;
    for (int k = 0; k < EFF_DEPTH; k++) begin
      if (nest_q == LW'(k + 1)) begin
        top_pc = stack_q[k].pc;
        top_id = stack_q[k].id;
      end
    end
  end

`ifdef INTC_NEST_EN
  assign prio_ok = (state_q == ST_IDLE) || (cand_id < top_id);
`else
  // Single level: handlers only re-enable through eret.
  logic unused_ie_set;
  assign unused_ie_set = ie_set;
  assign prio_ok       = (state_q == ST_IDLE);
`endif

  // eret blocks accept so the pop and a new push never share a cycle.
  assign accept = ie_q & cand_vld & ~eret & (state_q != ST_FULL) & prio_ok;
  assign pop    = eret & (state_q != ST_IDLE);

  // Global enable: accept beats eret beats ie_clr beats ie_set.
  always_comb begin
    ie_d = ie_q;
`ifdef INTC_NEST_EN
    if (ie_set) ie_d = 1'b1;
`endif
    if (ie_clr) ie_d = 1'b0;
    if (eret)   ie_d = 1'b1;
    if (accept) ie_d = 1'b0;
  end

  // One-hot masks for the channel being pushed and the one being popped.
  always_comb begin
    acc_onehot = '0;
    pop_onehot = '0;
    if (accept) acc_onehot[cand_id] = 1'b1;
    if (pop)    pop_onehot[top_id]  = 1'b1;
  end

  // Occupancy FSM: accept climbs one level, eret descends one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = (EFF_DEPTH == 1) ? ST_FULL : ST_ACTIVE;
      ST_ACTIVE: begin
        if (accept && nest_q == LW'(EFF_DEPTH - 1)) state_d = ST_FULL;
        else if (pop && nest_q == LW'(1))          state_d = ST_IDLE;
      end
      ST_FULL:   if (pop) state_d = (EFF_DEPTH == 1) ? ST_IDLE : ST_ACTIVE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Control state, request pulse and EPC stack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      irq_q        <= '0;
      pending_q    <= '0;
      mask_q       <= '1;
      ie_q         <= 1'b1;
      in_service_q <= '0;
      nest_q       <= '0;
      req_q        <= 1'b0;
      id_q         <= '0;
      vec_q        <= '0;
      for (int k = 0; k < EFF_DEPTH; k++) stack_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      irq_q        <= irq;
      // A fresh edge on the accepted channel re-arms it in the same cycle.
      pending_q    <= (pending_q & ~acc_onehot) | edge_v;
      if (mask_we) mask_q <= mask_din;
      ie_q         <= ie_d;
      in_service_q <= (in_service_q | acc_onehot) & ~pop_onehot;
      req_q        <= accept;
      if (accept) begin
        id_q   <= cand_id;
        vec_q  <= VEC_BASE + ADDR_W'(cand_id) * VEC_STRIDE;
        nest_q <= nest_q + LW'(1);
      end else if (pop) begin
        nest_q <= nest_q - LW'(1);
      end
      for (int k = 0; k < EFF_DEPTH; k++) begin
        if (accept && nest_q == LW'(k)) stack_q[k] <= '{pc: resume_pc, id: cand_id};
      end
    end
  end

  assign int_request = req_q;
  assign int_vector  = vec_q;
  assign int_id      = id_q;
  assign epc_out     = top_pc;
  assign ie          = ie_q;
  assign pending     = pending_q;
  assign in_service  = in_service_q;
  assign nest_level  = nest_q;
  assign stack_full  = (state_q == ST_FULL);

endmodule

// File: tb/tb_intc_nested.sv
// Directed bench for intc_nested (NUM_IRQ=4, NEST_DEPTH=2); adapts to INTC_NEST_EN.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_intc_nested;

`ifdef INTC_NEST_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq;
  logic        mask_we;
  logic [3:0]  mask_din;
  logic        ie_set, ie_clr, eret;
  logic [31:0] resume_pc;
  logic        int_request;
  logic [31:0] int_vector;
  logic [1:0]  int_id;
  logic [31:0] epc_out;
  logic        ie;
  logic [3:0]  pending, in_service;
  logic [1:0]  nest_level;
  logic        stack_full;

  int n_checks = 0;
  int n_errors = 0;

  intc_nested #(.NUM_IRQ(4), .NEST_DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .irq         (irq),
    .mask_we     (mask_we),
    .mask_din    (mask_din),
    .ie_set      (ie_set),
    .ie_clr      (ie_clr),
    .eret        (eret),
    .resume_pc   (resume_pc),
    .int_request (int_request),
    .int_vector  (int_vector),
    .int_id      (int_id),
    .epc_out     (epc_out),
    .ie          (ie),
    .pending     (pending),
    .in_service  (in_service),
    .nest_level  (nest_level),
    .stack_full  (stack_full)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_irq(input logic [3:0] v);
    irq = v;
    step(1);
    irq = '0;
  endtask

  task automatic do_eret();
    eret = 1'b1;
    step(1);
    eret = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq = '0; mask_we = 1'b0; mask_din = '0;
    ie_set = 1'b0; ie_clr = 1'b0; eret = 1'b0; resume_pc = '0;
    step(2);
    rst = 1'b0;
    check("rst_req",   int_request, 0);
    check("rst_vec",   int_vector,  0);
    check("rst_id",    int_id,      0);
    check("rst_epc",   epc_out,     0);
    check("rst_ie",    ie,          1);
    check("rst_pend",  pending,     0);
    check("rst_insvc", in_service,  0);
    check("rst_lvl",   nest_level,  0);
    check("rst_full",  stack_full,  0);

    // Single accept on channel 2.
    resume_pc = 32'h0000_3000;
    pulse_irq(4'b0100);
    check("t1_pend",  pending, 4'b0100);
    check("t1_noreq", int_request, 0);
    step(1);
    check("t1_req",   int_request, 1);
    check("t1_vec",   int_vector, 32'h600);
    check("t1_id",    int_id, 2);
    check("t1_epc",   epc_out, 32'h3000);
    check("t1_ie",    ie, 0);
    check("t1_lvl",   nest_level, 1);
    check("t1_insvc", in_service, 4'b0100);
    check("t1_clr",   pending, 0);
    check("t1_full",  stack_full, NEST ? 0 : 1);
    step(1);
    check("t1_pulse", int_request, 0);
    check("t1_hold",  int_vector, 32'h600);
    do_eret();
    check("t1_eret_lvl", nest_level, 0);
    check("t1_eret_ie",  ie, 1);
    check("t1_eret_epc", epc_out, 0);
    check("t1_eret_svc", in_service, 0);

    // Simultaneous sources 1 and 3.
    resume_pc = 32'h0000_3100;
    pulse_irq(4'b1010);
    step(1);
    check("t2_req",  int_request, 1);
    check("t2_id",   int_id, 1);
    check("t2_vec",  int_vector, 32'h500);
    check("t2_pend", pending, 4'b1000);
    step(2);
    check("t2_wait", int_request, 0);
    do_eret();
    check("t2_eret_req", int_request, 0);
    check("t2_eret_lvl", nest_level, 0);
    resume_pc = 32'h0000_7000;
    step(1);
    check("t2_req3", int_request, 1);
    check("t2_id3",  int_id, 3);
    check("t2_vec3", int_vector, 32'h700);
    check("t2_epc3", epc_out, 32'h7000);

    // ie_set while id 3 in service; re-raise of 3 must not be taken.
    ie_set = 1'b1; step(1); ie_set = 1'b0;
    check("t3_ieset", ie, NEST);
    pulse_irq(4'b1000);
    step(1);
    check("t3_self_noreq", int_request, 0);
    check("t3_self_pend",  pending, 4'b1000);

`ifdef INTC_NEST_EN
    resume_pc = 32'h0000_8000;
    pulse_irq(4'b0010);
    step(1);
    check("n_req1",  int_request, 1);
    check("n_id1",   int_id, 1);
    check("n_lvl2",  nest_level, 2);
    check("n_epc",   epc_out, 32'h8000);
    check("n_full",  stack_full, 1);
    check("n_insvc", in_service, 4'b1010);
    ie_set = 1'b1; step(1); ie_set = 1'b0;
    pulse_irq(4'b0001);
    step(1);
    check("n_full_noreq", int_request, 0);
    check("n_full_flag",  stack_full, 1);
    check("n_full_pend",  pending, 4'b1001);
    do_eret();
    check("n_pop_lvl", nest_level, 1);
    check("n_pop_epc", epc_out, 32'h7000);
    check("n_pop_svc", in_service, 4'b1000);
    step(1);
    check("n_req0", int_request, 1);
    check("n_id0",  int_id, 0);
    check("n_vec0", int_vector, 32'h400);
    check("n_lvl",  nest_level, 2);
    do_eret();
    do_eret();
    check("n_empty", nest_level, 0);
    step(1);
    check("n_req3_again", int_request, 1);
    check("n_id3_again",  int_id, 3);
    do_eret();
`else
    check("s_full", stack_full, 1);
    pulse_irq(4'b0001);
    step(1);
    check("s_full_noreq", int_request, 0);
    check("s_full_pend",  pending, 4'b1001);
    do_eret();
    check("s_pop_lvl", nest_level, 0);
    check("s_pop_ie",  ie, 1);
    step(1);
    check("s_req0", int_request, 1);
    check("s_id0",  int_id, 0);
    check("s_vec0", int_vector, 32'h400);
    do_eret();
    step(1);
    check("s_req3_again", int_request, 1);
    check("s_id3_again",  int_id, 3);
    do_eret();
`endif
    check("drain_pend", pending, 0);
    check("drain_lvl",  nest_level, 0);

    // ie_set/ie_clr contention and eret at an empty stack.
    ie_set = 1'b1; ie_clr = 1'b1; step(1); ie_set = 1'b0; ie_clr = 1'b0;
    check("ie_clr_wins", ie, 0);
    ie_set = 1'b1; step(1); ie_set = 1'b0;
    check("ie_set_only", ie, NEST);
    do_eret();
    check("ie_eret_idle", ie, 1);

    // Mask holds channel 2 pending until re-enabled.
    mask_we = 1'b1; mask_din = 4'b1011; step(1); mask_we = 1'b0;
    pulse_irq(4'b0100);
    step(2);
    check("m_noreq", int_request, 0);
    check("m_pend",  pending, 4'b0100);
    mask_we = 1'b1; mask_din = 4'b1111; step(1); mask_we = 1'b0;
    check("m_wr_noreq", int_request, 0);
    step(1);
    check("m_req", int_request, 1);
    check("m_id",  int_id, 2);
    check("m_vec", int_vector, 32'h600);
    do_eret();

    // eret coincident with an eligible candidate: eret wins.
    irq = 4'b0010; step(1); irq = '0;
    eret = 1'b1; step(1); eret = 1'b0;
    check("r1_noreq", int_request, 0);
    check("r1_pend",  pending, 4'b0010);
    step(1);
    check("r1_req", int_request, 1);
    check("r1_id",  int_id, 1);
    do_eret();

    // New edge on channel 1 in its own accept cycle keeps it pending.
    ie_clr = 1'b1; step(1); ie_clr = 1'b0;
    check("r2_ie0", ie, 0);
    pulse_irq(4'b0010);
    check("r2_pend", pending, 4'b0010);
    do_eret();
    check("r2_ie1",   ie, 1);
    check("r2_noreq", int_request, 0);
    irq = 4'b0010; step(1); irq = '0;
    check("r2_req",     int_request, 1);
    check("r2_id",      int_id, 1);
    check("r2_rearmed", pending, 4'b0010);
    do_eret();
    step(1);
    check("r2_req_again", int_request, 1);
    check("r2_pend_clr",  pending, 0);
    do_eret();

    // Reset mid-operation: request pulse and in-flight accept dropped.
    resume_pc = 32'h0000_9000;
    pulse_irq(4'b0100);
    step(1);
    check("x_req", int_request, 1);
    rst = 1'b1; step(1); rst = 1'b0;
    check("x_req_drop", int_request, 0);
    check("x_lvl",      nest_level, 0);
    check("x_epc",      epc_out, 0);
    check("x_svc",      in_service, 0);
    check("x_ie",       ie, 1);
    pulse_irq(4'b0010);
    rst = 1'b1; step(1); rst = 1'b0;
    check("x_inflight_req",  int_request, 0);
    check("x_inflight_pend", pending, 0);
    step(1);
    check("x_quiet", int_request, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/intc_nested.md
# intc_nested

Parametrised, prioritised interrupt controller for the write-back stage of the pipelined MIPS core. Latches edges on `NUM_IRQ` external lines, applies a per-channel mask and a global enable, and issues one-cycle interrupt requests carrying a computed vector. It saves the resume PC as EPC on a stack, so higher-priority sources can preempt a running handler, and restores state on ERET. It generalises the fixed four-line, single-level, hard-wired-vector controller used by WB.

## Interface
Parameters:
- `NUM_IRQ`, 4: number of interrupt lines; index 0 has the highest priority.
- `NEST_DEPTH`, 4: maximum nesting levels (EPC stack entries); must be ≥1.
- `ADDR_W`, 32: PC/vector width.
- `VEC_BASE`, 32'h0000_0400: vector of channel 0.
- `VEC_STRIDE`, 32'h0000_0100: vector spacing. Vector = `VEC_BASE + id*VEC_STRIDE`, truncated to `ADDR_W`.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `irq` in NUM_IRQ: raw interrupt lines; rising edges are latched.
- `mask_we` in 1: write strobe for the mask register.
- `mask_din` in NUM_IRQ: new mask value; 1 = channel enabled.
- `ie_set` in 1: set global enable (handler re-enables nesting).
- `ie_clr` in 1: clear global enable.
- `eret` in 1: ERET retiring in WB.
- `resume_pc` in ADDR_W: PC to save as EPC on accept (WB next-PC or PC+4, chosen upstream).
- `int_request` out 1: one-cycle request pulse to the PC mux.
- `int_vector` out ADDR_W: handler address; valid while `int_request` is high and held afterwards.
- `int_id` out clog2(NUM_IRQ): id of the accepted channel.
- `epc_out` out ADDR_W: EPC at the top of the stack; 0 when the stack is empty.
- `ie` out 1: global enable.
- `pending` out NUM_IRQ: latched edges not yet serviced.
- `in_service` out NUM_IRQ: channels currently on the stack.
- `nest_level` out clog2(NEST_DEPTH+1): stack occupancy.
- `stack_full` out 1: `nest_level == NEST_DEPTH`.

## Operation
- **Reset values.** `irq_q`, `pending`, `in_service`, `nest_level`, `int_request`, `int_id`, `int_vector`, `epc_out` all reset to 0. `mask` resets to all-ones and `ie` resets to 1. A line held high through reset is therefore latched on the first cycle after reset.
- **Edge capture.** `pending[i]` is set when `irq[i] & ~irq_q[i]`. It is cleared only when channel i is accepted. If a new edge arrives in the same cycle that channel i is accepted, `pending[i]` stays set.
- **Eligibility and priority.** `elig = pending & mask & ~in_service`. The candidate is the lowest set index of `elig`.
- **Accept condition:** `ie` is high, a candidate exists, `eret` is low, `stack_full` is low, and either `nest_level == 0` or the candidate id is less than the top-of-stack id.
- **On accept:**
  - push `{resume_pc, id}`;
  - set `nest_level++` and `in_service[id]`;
  - clear `pending[id]`;
  - set `ie` to 0 (overriding `ie_set`);
  - next cycle: `int_request = 1`, with `int_vector` and `int_id` updated.
- **On eret:**
  - if `nest_level > 0`: pop, clear `in_service` of the popped id, decrement `nest_level`, set `ie` to 1;
  - if `nest_level == 0`: set `ie` only.
- **Priority rules:**
  - `eret` and an eligible candidate in the same cycle: eret wins; the accept is re-evaluated next cycle.
  - `ie_set` and `ie_clr` in the same cycle: `ie_clr` wins.
  - Stack full: no accept; pending bits are held.
- **States:** IDLE (`nest_level == 0`), ACTIVE (1..NEST_DEPTH-1), FULL (`nest_level == NEST_DEPTH`). Accept moves up one state; eret moves down one state.

## Timing
- `irq` rise sampled at edge N → `pending` set at N → accept evaluated in cycle N..N+1 → `int_request` high for exactly the cycle after edge N+1. Latency is 2 cycles.
- `epc_out` and `nest_level` update on the same edge that raises `int_request`.
- `mask_we` takes effect for eligibility from the next cycle.
- Back-to-back accepts cannot occur without an intervening `ie_set`, because every accept clears `ie`.
- `rst` asserted mid-operation aborts everything: the stack is emptied and any in-flight request pulse is dropped.

## Configuration
- Macro `INTC_NEST_EN`.
  - **Defined:** nesting as described above.
  - **Undefined:** effective depth is 1. Accept requires `nest_level == 0`, the priority comparison against the top of stack is removed, and `ie_set` is ignored (only `eret` restores `ie`). This reproduces single-level CP0 behaviour.

## Structure
- Package `intc_pkg`:
  - width localparams `ID_W` and `LVL_W`;
  - typedef `intc_stack_entry_t` {pc, id};
  - function `ffs_lowest`.
- Sub-module `intc_prio_enc`: find-first-set priority encoder with a valid output, parametrised by `NUM_IRQ`.

## Test plan
- **Single accept:** reset; pulse `irq[2]` with `resume_pc = 0x0000_3000` → `int_request` 2 cycles later, `int_vector = 0x0000_0600`, `epc_out = 0x3000`, `ie = 0`, `nest_level = 1`.
- **Simultaneous sources:** `irq[1]` and `irq[3]` rise together → id 1 accepted (vector 0x500). After ERET, id 3 is accepted (0x700) once `ie` is high again.
- **Preemption:** in service of id 3 with `ie_set` pulsed; raise `irq[0]` → accepted with `nest_level = 2`. First ERET gives `epc_out` = the saved PC of id 3. Raising `irq[3]` again while id 3 is in service is not accepted.
- **Mask:** write `mask = 4'b1011`, pulse `irq[2]` → no request, `pending[2] = 1`. Write `mask = 4'b1111` → request for id 2 with vector 0x600.
- **Stack full:** with `NEST_DEPTH = 2`, take nested ids 3 then 1, then pulse `irq[0]` → no request and `stack_full = 1`. After one ERET, id 0 is accepted.
- **Races:** `eret` coincident with an eligible edge → the pop happens first and the request follows one cycle later. Edge on channel i during its accept cycle → `pending[i]` remains 1.
